// File: rtl/rx_wb_capture.sv
// rx_wb_capture: circular sample buffer after the first wideband CIC stage.
// Stores strobed signed I/Q pairs and serves each stored sample to the CPU
// readout path as three 16-bit words: I low, Q low, then {sext8(I hi), sext8(Q hi)}.
//
// Readout handshake: rd_dout always shows the word at the head of the buffer
// (or 16'h0000 when empty). A one-cycle rd_word pulse means "this word has been
// taken". It is honoured only while count > 0. The third word of a sample pops it.
// in_strobe is a one-cycle "sample valid" pulse with no back-pressure. A sample
// that arrives while the buffer is full and nothing is popped is dropped, and
// this sets the sticky overflow flag.
module rx_wb_capture #(
    parameter int WIDTH  = 18,
    parameter int AW     = 9,
    parameter int NSAMPS = 256
) (
    input  logic             adc_clk,
    input  logic             reset,
    input  logic             in_strobe,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] in_q,
    input  logic             rd_word,
    output logic [15:0]      rd_dout,
    output logic [AW:0]      count,
    output logic             ready,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0]   DEPTH_C  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   NSAMPS_C = NSAMPS[AW:0];
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Word phase within the head sample.
    localparam logic [1:0] PH_I  = 2'd0;
    localparam logic [1:0] PH_Q  = 2'd1;
    localparam logic [1:0] PH_HI = 2'd2;

    logic [2*WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [1:0]    ph_q,     ph_d;
    logic          ovf_q,    ovf_d;

    logic nonempty;
    logic rd_adv;
    logic pop;
    logic wr_acc;
    logic wr_drop;

    logic [2*WIDTH-1:0]     head;
    logic signed [WIDTH-1:0] head_i;
    logic signed [WIDTH-1:0] head_q;
    logic [7:0]              hi_i;
    logic [7:0]              hi_q;

    // Accept/pop decisions and next-state values for pointers, count, phase, overflow.
    always_comb begin
        nonempty = (count_q != '0);
        rd_adv   = rd_word && nonempty;
        pop      = rd_adv && (ph_q == PH_HI);
        // A pop in the same cycle frees the slot, so a write at full is still taken.
        wr_acc   = in_strobe && ((count_q != DEPTH_C) || pop);
        wr_drop  = in_strobe && !wr_acc;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ph_d     = ph_q;
        ovf_d    = ovf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (rd_adv) begin
            ph_d = (ph_q == PH_HI) ? PH_I : ph_q + 2'd1;
        end

        // Set has priority over clear so a drop is never lost.
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ph_q     <= PH_I;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ph_q     <= ph_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; contents need no reset, only the pointers matter.
    always_ff @(posedge adc_clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr_q] <= {in_i, in_q};
        end
    end

    // Readout mux: asynchronous read of the head sample, word selected by phase.
    always_comb begin
        head   = mem[rd_ptr_q];
        head_i = head[2*WIDTH-1:WIDTH];
        head_q = head[WIDTH-1:0];
        // Arithmetic shift sign-extends the high part; low byte is sext8(hi).
        hi_i   = 8'(head_i >>> 16);
        hi_q   = 8'(head_q >>> 16);

        rd_dout = 16'h0000;
        if (nonempty) begin
            case (ph_q)
                PH_I:    rd_dout = head_i[15:0];
                PH_Q:    rd_dout = head_q[15:0];
                PH_HI:   rd_dout = {hi_i, hi_q};
                default: rd_dout = 16'h0000;
            endcase
        end
    end

    assign count    = count_q;
    assign ready    = (count_q >= NSAMPS_C);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_rx_wb_capture.sv
// Bench for rx_wb_capture: directed scenarios plus a randomized phase, checked
// against a queue-based model of the buffer's word stream.
module tb_rx_wb_capture;

    localparam int W      = 18;
    localparam int AW     = 9;
    localparam int DEPTH  = 1 << AW;
    localparam int NSAMPS = 256;

    logic          adc_clk;
    logic          reset;
    logic          in_strobe;
    logic [W-1:0]  in_i;
    logic [W-1:0]  in_q;
    logic          rd_word;
    logic [15:0]   rd_dout;
    logic [AW:0]   count;
    logic          ready;
    logic          overflow;
    logic          clr_ovf;

    rx_wb_capture #(.WIDTH(W), .AW(AW), .NSAMPS(NSAMPS)) dut (
        .adc_clk   (adc_clk),
        .reset     (reset),
        .in_strobe (in_strobe),
        .in_i      (in_i),
        .in_q      (in_q),
        .rd_word   (rd_word),
        .rd_dout   (rd_dout),
        .count     (count),
        .ready     (ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // ---------------- clock / reset ----------------
    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];   // words the readout path should see, in order
    int m_cnt;               // samples held
    int m_taken;             // words already taken from the head sample
    int m_ovf;
    int checks;
    int errors;
    bit mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // floor(v / 65536) reduced to a byte: the sign-extended high part of a sample.
    function automatic logic [7:0] high_byte(input logic [W-1:0] s);
        int v;
        int h;
        v = int'(s);
        if (v >= (1 << (W - 1))) v = v - (1 << W);
        if (v >= 0) h = v / 65536;
        else        h = -((-v + 65535) / 65536);
        return 8'(h);
    endfunction

    // Reference model: updates on each active edge from the inputs of that cycle.
    always @(posedge adc_clk) begin
        bit pop;
        bit acc;
        if (reset) begin
            exp_q.delete();
            m_cnt   = 0;
            m_taken = 0;
            m_ovf   = 0;
        end else begin
            pop = rd_word && (m_cnt > 0) && (m_taken == 2);
            if (rd_word && m_cnt > 0) m_taken = (m_taken == 2) ? 0 : m_taken + 1;
            acc = in_strobe && ((m_cnt < DEPTH) || pop);
            if (acc) begin
                exp_q.push_back(in_i[15:0]);
                exp_q.push_back(in_q[15:0]);
                exp_q.push_back({high_byte(in_i), high_byte(in_q)});
            end
            if (in_strobe && !acc) m_ovf = 1;
            else if (clr_ovf)      m_ovf = 0;
            m_cnt = m_cnt + int'(acc) - int'(pop);
        end
    end

    // Monitor: mid-cycle, compare status and the presented word; pop when taken.
    always @(negedge adc_clk) begin
        logic [15:0] w;
        if (mon_en) begin
            check("count", 32'(count), m_cnt);
            check("ready", 32'(ready), (m_cnt >= NSAMPS) ? 1 : 0);
            check("overflow", 32'(overflow), m_ovf);
            if (m_cnt == 0) begin
                check("rd_dout_empty", 32'(rd_dout), 0);
            end else if (exp_q.size() == 0) begin
                check("model_words_avail", 0, 1);
            end else if (rd_word && !reset) begin
                w = exp_q.pop_front();
                check("rd_dout_taken", 32'(rd_dout), 32'(w));
            end else begin
                check("rd_dout_head", 32'(rd_dout), 32'(exp_q[0]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic s, input logic [W-1:0] i, input logic [W-1:0] q,
                         input logic r, input logic c);
        in_strobe = s;
        in_i      = i;
        in_q      = q;
        rd_word   = r;
        clr_ovf   = c;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic reads(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 0;
        m_cnt     = 0;
        m_taken   = 0;
        m_ovf     = 0;
        reset     = 1'b1;
        in_strobe = 1'b0;
        in_i      = '0;
        in_q      = '0;
        rd_word   = 1'b0;
        clr_ovf   = 1'b0;
        @(posedge adc_clk);
        #1;
        mon_en = 1;
        idle(1);
        reset = 1'b0;

        // Three identical samples, nine words out, then empty reads.
        for (int k = 0; k < 3; k++) drive(1'b1, 18'h1_2345, 18'h2_ABCD, 1'b0, 1'b0);
        reads(11);

        // Fill to full, one dropped sample, then clear the sticky flag.
        for (int k = 0; k < DEPTH; k++) drive(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        drive(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        idle(1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Full buffer: strobe together with the popping third word.
        reads(2);
        drive(1'b1, 18'h3_FFFF, 18'h2_0000, 1'b1, 1'b0);
        idle(1);

        // Drain everything.
        reads(3 * DEPTH);
        idle(1);

        // Empty reads are ignored; then one sample round-trips.
        reads(5);
        drive(1'b1, 18'h2_8001, 18'h1_7FFE, 1'b1, 1'b0);
        reads(4);

        // Continuous write + read with incrementing data, wraps the pointers.
        for (int k = 0; k < 600; k++) drive(1'b1, W'(k), W'(k + 1000), 1'b1, 1'b0);

        // Randomized mix, including drops and clears.
        for (int k = 0; k < 2500; k++) begin
            drive(1'($urandom_range(0, 1)), rnd(), rnd(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Reset mid-operation with 100 samples held and ph=1.
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) drive(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        reads(1);
        reset = 1'b1;
        drive(1'b1, rnd(), rnd(), 1'b1, 1'b0);
        reset = 1'b0;
        idle(1);
        drive(1'b1, 18'h0_1234, 18'h3_8765, 1'b0, 1'b0);
        reads(4);
        idle(2);

        check("words_outstanding", exp_q.size(), 3 * m_cnt - m_taken);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
